// File: rtl/img_cpu_reader_fifo.sv
// img_cpu_reader_fifo: captures one frame between img_done markers,
// optionally decimates it, and buffers pixels in a FWFT FIFO for the CPU.
// Ports: clk_clk/reset_reset_n (async, active-low); producer side
// pix_rdy/pixel_data/img_done; CPU side start/get_next_pix/decim;
// status pix_rgb_out/pix_valid/cpu_rdy/frame_done/overflow/fifo_level/
// pix_cnt/out_state. Define IMG_READER_DROP_CNT_EN to add drop_cnt.
module img_cpu_reader_fifo #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   pix_rdy,
  input  logic [PIX_W-1:0]       pixel_data,
  input  logic                   img_done,
  input  logic                   start,
  input  logic                   get_next_pix,
  input  logic [3:0]             decim,
  output logic [PIX_W-1:0]       pix_rgb_out,
  output logic                   pix_valid,
  output logic                   cpu_rdy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       pix_cnt,
`ifdef IMG_READER_DROP_CNT_EN
  output logic [15:0]            drop_cnt,
`endif
  output logic [3:0]             out_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ARMED   = 4'd1,
    CAPTURE = 4'd2,
    DRAIN   = 4'd3,
    DONE    = 4'd4
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [3:0]       decim_q, decim_d;
  logic             cpu_rdy_q, done_q;
`ifdef IMG_READER_DROP_CNT_EN
  logic [15:0]      drop_q, drop_d;
`endif

  logic [PIX_W-1:0] mem [DEPTH];

  logic pop, keep, full, push, drop, wen;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dcnt_d  = dcnt_q;
    decim_d = decim_q;
`ifdef IMG_READER_DROP_CNT_EN
    drop_d  = drop_q;
`endif
    pop  = get_next_pix && (lvl_q != '0);
    keep = (state_q == CAPTURE) && pix_rdy
           && (dcnt_q == 4'd0);
    full = (lvl_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot.
    push = keep && (!full || pop);
    drop = keep && full && !pop;
    wen  = push && !start;

    if (start) begin
      // Abort-and-rearm from any state.
      state_d = ARMED;
      wr_d    = '0;
      rd_d    = '0;
      lvl_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      dcnt_d  = 4'd0;
      decim_d = decim;
`ifdef IMG_READER_DROP_CNT_EN
      drop_d  = '0;
`endif
    end else begin
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      lvl_d = lvl_q + LW'(push) - LW'(pop);
      if ((state_q == CAPTURE) && pix_rdy)
        dcnt_d = (dcnt_q == decim_q) ? 4'd0
                                     : dcnt_q + 4'd1;
      if (push && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
`ifdef IMG_READER_DROP_CNT_EN
        if (drop_q != '1) drop_d = drop_q + 16'd1;
`endif
      end
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (img_done) state_d = CAPTURE;
        CAPTURE: if (img_done) state_d = DRAIN;
        DRAIN:   if (lvl_q == '0) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      dcnt_q    <= 4'd0;
      decim_q   <= 4'd0;
      cpu_rdy_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef IMG_READER_DROP_CNT_EN
      drop_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      dcnt_q    <= dcnt_d;
      decim_q   <= decim_d;
      cpu_rdy_q <= (state_d == ARMED)
                || (state_d == CAPTURE);
      done_q    <= (state_d == DONE);
`ifdef IMG_READER_DROP_CNT_EN
      drop_q    <= drop_d;
`endif
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk_clk) begin
    if (wen) mem[wr_q] <= pixel_data;
  end

  assign pix_valid   = (lvl_q != '0);
  assign pix_rgb_out = pix_valid ? mem[rd_q] : '0;
  assign cpu_rdy     = cpu_rdy_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  assign fifo_level  = lvl_q;
  assign pix_cnt     = cnt_q;
  assign out_state   = state_q;
`ifdef IMG_READER_DROP_CNT_EN
  assign drop_cnt    = drop_q;
`endif

endmodule

// File: doc/img_cpu_reader_fifo.md
# img_cpu_reader_fifo

Parametrised successor to the single-pixel CPU image reader in the camera subsystem. It sits between the D8M pixel pipeline and the Nios pixel-transfer software. It captures one whole frame between frame markers, optionally decimates it, and buffers pixels in a DEPTH-entry first-word-fall-through FIFO, so the CPU can pop pixels at its own pace. Frame status, pixel count and overflow status are exposed for the CPU.

## Interface
Parameters:
- PIX_W, 24, pixel width in bits (RGB888 by default)
- DEPTH, 16, FIFO entries; power of two, at least 2
- CNT_W, 32, width of the frame pixel counter

Ports:
- clk_clk  in  1  system clock; all logic is rising-edge
- reset_reset_n  in  1  asynchronous, active-low reset
- pix_rdy  in  1  producer strobe; one pixel offered per cycle high
- pixel_data  in  PIX_W  producer pixel, qualified by pix_rdy
- img_done  in  1  producer end-of-frame pulse, one cycle
- start  in  1  CPU arm pulse
- get_next_pix  in  1  CPU pop request; one pop per cycle high while pix_valid
- decim  in  4  keep 1 of every decim+1 offered pixels; latched on start
- pix_rgb_out  out  PIX_W  FIFO head
- pix_valid  out  1  FIFO not empty
- cpu_rdy  out  1  high in ARMED or CAPTURE
- frame_done  out  1  high in DONE
- overflow  out  1  sticky; a kept pixel was dropped because the FIFO was full
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- pix_cnt  out  CNT_W  kept pixels written this frame; excludes dropped pixels
- out_state  out  4  state encoding

## Operation
States and out_state encoding: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, DONE=4.
- IDLE: start moves to ARMED. On that transition the FIFO is flushed, pix_cnt, overflow and the decimation counter are cleared, and decim is latched.
- ARMED: pixels are ignored. img_done moves to CAPTURE, so capture always begins at a frame boundary.
- CAPTURE: on each pix_rdy the decimation counter is checked. If it is 0, the pixel is kept. The counter then increments, wrapping to 0 when it reaches the latched decim value. A kept pixel is pushed if the FIFO is not full. If the FIFO is full, the pixel is dropped and overflow is set. img_done moves to DRAIN; a pix_rdy in that same cycle is still processed.
- DRAIN: pixels are ignored. When the FIFO is empty, the block moves to DONE.
- DONE: holds frame_done. start restarts the sequence exactly as from IDLE.
- A start in any non-IDLE state acts as an abort-and-rearm: flush, clear, go to ARMED.
- Pop: get_next_pix with pix_valid removes the head. get_next_pix with pix_valid low is ignored.
- Full plus simultaneous push and pop: the pop frees the slot, so the push is accepted and no overflow occurs.
- Empty plus simultaneous push and pop: the pop is ignored and the push is accepted.
- pix_cnt saturates at all-ones.
- fifo_level equals pushes minus pops. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - out_state=0 (IDLE)
  - pix_valid=0, cpu_rdy=0, frame_done=0, overflow=0
  - fifo_level=0, pix_cnt=0
  - pix_rgb_out=0
- Push latency: a pixel accepted in cycle N appears on pix_rgb_out with pix_valid=1 in cycle N+1 if the FIFO was empty.
- Pop latency: after a pop in cycle N, the next head (or pix_valid=0) is presented in cycle N+1.
- All outputs are registered or driven from registers; no combinational path from input to output.
- State changes take effect in the cycle after the triggering input.
- An empty FIFO in DRAIN causes DONE on the next cycle.
- Asserting reset at any point clears all state immediately, including mid-capture.

## Configuration
- IMG_READER_DROP_CNT_EN defined:
  - adds output port drop_cnt (out, 16 bits), a saturating count of dropped kept pixels;
  - drop_cnt is cleared alongside overflow;
  - its reset value is 0.
- IMG_READER_DROP_CNT_EN undefined: the port and its counter are absent; only the sticky overflow flag reports drops.

## Test plan
- Basic capture: start, img_done, 5 pixels 0x000001..0x000005, img_done -> state sequence 1,2,3. The CPU pops 0x000001..0x000005 in order, pix_cnt=5, and DONE follows the last pop.
- Decimation: decim=2 with 9 pixels 0..8 -> FIFO holds 0, 3, 6, and pix_cnt=3.
- Overflow: DEPTH=16 with 20 pixels and no pops -> fifo_level=16, overflow=1, pix_cnt=16, and drop_cnt=4 when IMG_READER_DROP_CNT_EN is defined.
- Full with simultaneous push and pop: FIFO full, pix_rdy and get_next_pix in the same cycle -> fifo_level stays 16 and overflow stays 0.
- Frame boundary: pixels before the first img_done in ARMED -> none are captured, fifo_level=0.
- Abort and reset: start mid-CAPTURE with 7 entries -> FIFO flushed and state 1. Then reset_reset_n low mid-CAPTURE -> all outputs at reset values in the same cycle.
